// File: rtl/riscv_rf_wb_arbiter.sv
// Write-back arbiter in front of the RF write port: merges an unbuffered ALU
// channel with a FIFO-buffered load channel, one registered write per cycle.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   alu_valid/ready/addr/data ALU result handshake (ready depends on alu_addr)
//   ld_valid/ready/addr/data  load result handshake into the load FIFO
//   rf_wr_en/addr/data_in     registered RF write port
//   ld_fifo_count             current load FIFO occupancy
//   idle                      FIFO empty and no write in flight
module riscv_rf_wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [ADDR_WIDTH-1:0]         alu_addr,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [ADDR_WIDTH-1:0]         ld_addr,
  input  logic [DATA_WIDTH-1:0]         ld_data,
  output logic                          rf_wr_en,
  output logic [ADDR_WIDTH-1:0]         rf_wr_addr,
  output logic [DATA_WIDTH-1:0]         rf_data_in,
  output logic [$clog2(FIFO_DEPTH):0]   ld_fifo_count,
  output logic                          idle
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_WIDTH-1:0] r_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_data [FIFO_DEPTH];
  logic [PW-1:0]         r_wp;
  logic [PW-1:0]         r_rp;
  logic [CW-1:0]         r_cnt;
  logic [SW-1:0]         r_starve;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_hit;
  logic                  w_starve;
  logic                  w_alu_gnt;
  logic                  w_ld_gnt;
  logic                  w_enq;
  logic [PW-1:0]         w_off [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_data;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CW'(FIFO_DEPTH));
  assign w_starve = !w_empty && (r_starve == SW'(STARVE_LIMIT));

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_off[i] = PW'(i) - r_rp;
      if ((CW'(w_off[i]) < r_cnt) && (r_addr[i] == alu_addr))
        w_hit = 1'b1;
    end
    w_hit = w_hit && alu_valid && (alu_addr != '0);
  end

  assign alu_ready = !rst && !w_hit && !w_starve;
  assign ld_ready  = !rst && !w_full;

  assign w_alu_gnt = alu_valid && alu_ready;
  assign w_ld_gnt  = !w_alu_gnt && !w_empty;
  assign w_enq     = ld_valid && ld_ready;

  assign w_win_addr = w_alu_gnt ? alu_addr : r_addr[r_rp];
  assign w_win_data = w_alu_gnt ? alu_data : r_data[r_rp];

  // Storage needs no reset: liveness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_wp] <= ld_addr;
      r_data[r_wp] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_enq)
        r_wp <= r_wp + PW'(1);
      if (w_ld_gnt)
        r_rp <= r_rp + PW'(1);
      unique case ({w_enq, w_ld_gnt})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_empty || w_ld_gnt) begin
      r_starve <= '0;
    end else if (w_alu_gnt && !w_starve) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // x0 results are consumed but never reach the RF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_alu_gnt || w_ld_gnt) begin
      r_wr_en   <= (w_win_addr != '0);
      r_wr_addr <= w_win_addr;
      r_wr_data <= w_win_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign rf_wr_en      = r_wr_en;
  assign rf_wr_addr    = r_wr_addr;
  assign rf_data_in    = r_wr_data;
  assign ld_fifo_count = r_cnt;
  assign idle          = w_empty && !r_wr_en;

endmodule

// File: tb/tb_riscv_rf_wb_arbiter.sv
// Testbench for riscv_rf_wb_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_riscv_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 4;
  localparam int SL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          ld_valid, ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_data_in;
  logic [2:0]    ld_fifo_count;
  logic          idle;

  always #5 clk = ~clk;

  riscv_rf_wb_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .FIFO_DEPTH(D), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_data_in(rf_data_in),
    .ld_fifo_count(ld_fifo_count), .idle(idle)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  int            sc;
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  int   passed = 0;
  int   total  = 0;
  logic s_ar, s_lr, g_aacc, g_lacc;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    sc = 0;
    m_en = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One clock cycle: drive, check readies, advance model, check outputs.
  task automatic cyc(input logic av, input logic [AW-1:0] aa,
                     input logic [DW-1:0] ad, input logic lv,
                     input logic [AW-1:0] la, input logic [DW-1:0] ldd);
    bit   ne, hit, e_ar, e_lr;
    ent_t e;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_valid = lv; ld_addr = la; ld_data = ldd;
    #1;
    ne  = (q.size() > 0);
    hit = 0;
    foreach (q[i]) if (q[i].a == aa) hit = 1;
    hit  = hit && av && (aa != 0);
    e_ar = !hit && !(ne && sc == SL);
    e_lr = (q.size() < D);
    s_ar = alu_ready;
    s_lr = ld_ready;
    chk("alu_ready", {63'd0, alu_ready}, {63'd0, e_ar});
    chk("ld_ready", {63'd0, ld_ready}, {63'd0, e_lr});
    g_aacc = av && e_ar;
    g_lacc = lv && e_lr;
    if (g_aacc) begin
      m_en = (aa != 0); m_addr = aa; m_data = ad;
      sc = ne ? ((sc < SL) ? sc + 1 : SL) : 0;
    end else if (ne) begin
      e = q.pop_front();
      m_en = (e.a != 0); m_addr = e.a; m_data = e.d;
      sc = 0;
    end else begin
      m_en = 1'b0;
      sc = 0;
    end
    if (g_lacc) begin
      e.a = la; e.d = ldd;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("rf_wr_en", {63'd0, rf_wr_en}, {63'd0, m_en});
    chk("rf_wr_addr", 64'(rf_wr_addr), 64'(m_addr));
    chk("rf_data_in", 64'(rf_data_in), 64'(m_data));
    chk("count", 64'(ld_fifo_count), 64'(q.size()));
    chk("idle", {63'd0, idle}, {63'd0, (q.size() == 0) && !m_en});
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_en"}, {63'd0, rf_wr_en}, 64'd0);
    chk({tag, "_addr"}, 64'(rf_wr_addr), 64'd0);
    chk({tag, "_data"}, 64'(rf_data_in), 64'd0);
    chk({tag, "_cnt"}, 64'(ld_fifo_count), 64'd0);
    chk({tag, "_ardy"}, {63'd0, alu_ready}, 64'd0);
    chk({tag, "_lrdy"}, {63'd0, ld_ready}, 64'd0);
  endtask

  logic          pa_v, pl_v;
  logic [AW-1:0] pa_a, pl_a;
  logic [DW-1:0] pa_d, pl_d;

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_addr = '0; alu_data = '0;
    ld_valid = 0; ld_addr = '0; ld_data = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_reset_state("por");
    chk("por_idle", {63'd0, idle}, 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Mid-stream reset with three buffered loads
    cyc(1, 5'd9, 32'h99, 1, 5'd1, 32'h11);
    cyc(1, 5'd9, 32'h99, 1, 5'd2, 32'h22);
    cyc(1, 5'd9, 32'h99, 1, 5'd3, 32'h33);
    chk("t1_cnt3", 64'(ld_fifo_count), 64'd3);
    chk("t1_en", {63'd0, rf_wr_en}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset_state("t1_rst");
    model_reset();
    @(negedge clk);
    alu_valid = 0; ld_valid = 0;
    rst = 1'b0;
    cyc(0, '0, '0, 0, '0, '0);
    cyc(0, '0, '0, 0, '0, '0);
    chk("t1_idle", {63'd0, idle}, 64'd1);
    chk("t1_noen", {63'd0, rf_wr_en}, 64'd0);

    // ALU only, including x0 drop
    cyc(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    chk("t2_en", {63'd0, rf_wr_en}, 64'd1);
    chk("t2_addr", 64'(rf_wr_addr), 64'd5);
    chk("t2_data", 64'(rf_data_in), 64'hDEADBEEF);
    cyc(1, 5'd0, 32'h1, 0, '0, '0);
    chk("t2_x0_rdy", {63'd0, s_ar}, 64'd1);
    chk("t2_x0_en", {63'd0, rf_wr_en}, 64'd0);

    // Load only, back to back
    for (int i = 0; i < 6; i++) begin
      cyc(0, '0, '0, i < 4, AW'(i + 1), DW'(32'h100 + i + 1));
      if (i == 0)
        chk("t3_lat", {63'd0, rf_wr_en}, 64'd0);
      else if (i <= 4)
        chk("t3_order", 64'(rf_wr_addr), 64'(i));
    end

    // Fill with x0 ALU traffic, then full + dequeue: count 4,3,4
    for (int i = 0; i < 4; i++)
      cyc(1, 5'd0, '0, 1, AW'(10 + i), DW'(32'h200 + i));
    chk("t6_full", 64'(ld_fifo_count), 64'd4);
    cyc(0, '0, '0, 1, 5'd14, 32'h204);
    chk("t6_lrdy_full", {63'd0, s_lr}, 64'd0);
    chk("t6_cnt3", 64'(ld_fifo_count), 64'd3);
    cyc(1, 5'd0, '0, 1, 5'd14, 32'h204);
    chk("t6_cnt4", 64'(ld_fifo_count), 64'd4);
    for (int i = 0; i < 6; i++)
      cyc(0, '0, '0, 0, '0, '0);

    // Starvation bound
    cyc(1, 5'd9, 32'h90, 1, 5'd7, 32'h77);
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 5'd9, 32'h90, 0, '0, '0);
      chk("t4_ardy", {63'd0, s_ar}, {63'd0, k != 4});
      if (k == 4)
        chk("t4_ld_addr", 64'(rf_wr_addr), 64'd7);
    end

    // Same-register hazard
    cyc(0, '0, '0, 1, 5'd3, 32'hAA);
    cyc(1, 5'd3, 32'hBB, 0, '0, '0);
    chk("t5_stall", {63'd0, s_ar}, 64'd0);
    chk("t5_first", 64'(rf_data_in), 64'hAA);
    cyc(1, 5'd3, 32'hBB, 0, '0, '0);
    chk("t5_go", {63'd0, s_ar}, 64'd1);
    chk("t5_second", 64'(rf_data_in), 64'hBB);

    // Random traffic on a small register set to provoke hazards
    pa_v = 0; pl_v = 0;
    pa_a = '0; pl_a = '0; pa_d = '0; pl_d = '0;
    for (int n = 0; n < 600; n++) begin
      if (!pa_v && $urandom_range(0, 99) < 55) begin
        pa_v = 1;
        pa_a = AW'($urandom_range(0, 7));
        pa_d = $urandom;
      end
      if (!pl_v && $urandom_range(0, 99) < 45) begin
        pl_v = 1;
        pl_a = AW'($urandom_range(0, 7));
        pl_d = $urandom;
      end
      cyc(pa_v, pa_a, pa_d, pl_v, pl_a, pl_d);
      if (g_aacc) pa_v = 0;
      if (g_lacc) pl_v = 0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
